// File: rtl/adc_promedio_movil.sv
// Sliding-window average of ADC samples over 2^LOG2_N entries.
// Asynchronous sample flag is synchronized and edge-detected on clk.
module adc_promedio_movil #(
  parameter int WIDTH  = 12,
  parameter int LOG2_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] dato_in,
  input  logic             listo_in,
  output logic [WIDTH-1:0] prom_out,
  output logic             prom_valid,
  output logic             ventana_llena,
  output logic             overrun
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = WIDTH + LOG2_N;

  localparam logic [LOG2_N:0]   NC      = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [LOG2_N:0]   CNT_ONE = 1;
  localparam logic [LOG2_N-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    UPDATE,
    OUT
  } state_t;

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [LOG2_N-1:0] ptr_q;
  logic [LOG2_N:0]   cnt_q, cnt_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [WIDTH-1:0]  muestra_q, rd_q, viejo;
  logic [WIDTH-1:0]  prom_q;
  logic              valid_q, llena_q, ovr_q;
  logic              strobe, full, wr_en;
  logic [WIDTH-1:0]  mem_q [N];

  assign strobe = s2_q & ~s3_q;
  assign full   = (cnt_q == NC);
  assign viejo  = full ? rd_q : '0;
  assign sum_d  = sum_q + SW'(muestra_q) - SW'(viejo);
  assign cnt_d  = full ? cnt_q : cnt_q + CNT_ONE;
  assign wr_en  = (state_q == UPDATE) & ~rst & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= listo_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Buffer contents survive reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[ptr_q] <= muestra_q;
    if (state_q == READ)
      rd_q <= mem_q[ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      muestra_q <= '0;
      prom_q    <= '0;
      valid_q   <= 1'b0;
      llena_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (strobe && state_q != IDLE)
        ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (strobe) begin
            muestra_q <= dato_in;
            state_q   <= READ;
          end
        end
        READ: begin
          state_q <= UPDATE;
        end
        UPDATE: begin
          sum_q   <= sum_d;
          ptr_q   <= ptr_q + PTR_ONE;
          cnt_q   <= cnt_d;
          llena_q <= (cnt_d == NC);
          state_q <= OUT;
        end
        OUT: begin
          if (full) begin
            prom_q  <= sum_q[SW-1:LOG2_N];
            valid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prom_out      = prom_q;
  assign prom_valid    = valid_q;
  assign ventana_llena = llena_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_adc_promedio_movil.sv
// Scoreboard bench for adc_promedio_movil.
// Window model pushes expected averages; monitor pops on prom_valid.
module tb_adc_promedio_movil;

  logic        clk = 1'b0;
  logic        rst, clr, listo_in;
  logic [11:0] dato_in;
  logic [11:0] prom_out;
  logic        prom_valid, ventana_llena, overrun;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_valid = 0;
  int          win[$];
  logic [11:0] expq[$];
  logic        pv[6];
  int          v0;

  adc_promedio_movil #(.WIDTH(12), .LOG2_N(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .dato_in      (dato_in),
    .listo_in     (listo_in),
    .prom_out     (prom_out),
    .prom_valid   (prom_valid),
    .ventana_llena(ventana_llena),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [11:0] v);
    int s;
    win.push_back(int'(v));
    if (win.size() > 8)
      void'(win.pop_front());
    if (win.size() == 8) begin
      s = 0;
      foreach (win[i]) s += win[i];
      expq.push_back(12'(s / 8));
    end
  endtask

  task automatic model_clear();
    win.delete();
  endtask

  task automatic send(input logic [11:0] v, input int hi, input int lo);
    @(posedge clk);
    #1;
    dato_in  = v;
    listo_in = 1'b1;
    model_push(v);
    repeat (hi) @(posedge clk);
    #1 listo_in = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    if (prom_valid === 1'b1) begin
      n_valid++;
      if (expq.size() == 0)
        chk("unexpected_valid", 32'd1, 32'd0);
      else
        chk("prom_out", prom_out, expq.pop_front());
      chk("llena_at_valid", ventana_llena, 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; listo_in = 1'b0; dato_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_prom", prom_out, 0);
    chk("rst_valid", prom_valid, 0);
    chk("rst_llena", ventana_llena, 0);
    chk("rst_ovr", overrun, 0);

    // fill with 0x800, latency checked on the 8th sample
    for (int i = 0; i < 7; i++) send(12'h800, 20, 20);
    chk("fill_no_valid", n_valid, 0);
    chk("fill_llena", ventana_llena, 0);
    chk("fill_prom", prom_out, 0);
    @(posedge clk);
    #1;
    dato_in = 12'h800; listo_in = 1'b1;
    model_push(12'h800);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      pv[i] = prom_valid;
    end
    chk("lat_e4", pv[4], 0);
    chk("lat_e5", pv[5], 1);
    @(negedge clk);
    chk("pulse_once", prom_valid, 0);
    repeat (13) @(posedge clk);
    #1 listo_in = 1'b0;
    repeat (20) @(posedge clk);
    chk("full_prom", prom_out, 12'h800);
    chk("full_llena", ventana_llena, 1);
    chk("full_count", n_valid, 1);

    for (int i = 0; i < 8; i++) send(12'hFFF, 20, 20);
    chk("fff_prom", prom_out, 12'hFFF);
    for (int i = 0; i < 8; i++) send(12'h000, 20, 20);
    chk("zero_prom", prom_out, 12'h000);

    // overrun: high 1, low 1, high 1
    @(posedge clk);
    #1;
    dato_in = 12'h123; listo_in = 1'b1;
    model_push(12'h123);
    @(posedge clk);
    #1 listo_in = 1'b0;
    @(posedge clk);
    #1 listo_in = 1'b1;
    repeat (20) @(posedge clk);
    #1 listo_in = 1'b0;
    repeat (20) @(posedge clk);
    chk("ovr_set", overrun, 1);
    send(12'h456, 20, 20);
    chk("ovr_sticky", overrun, 1);
    pulse_clr();
    @(negedge clk);
    chk("ovr_clr", overrun, 0);
    chk("clr_llena", ventana_llena, 0);
    chk("clr_prom", prom_out, 0);

    // clr concurrent with a strobe
    for (int i = 0; i < 8; i++) send(12'h100, 20, 20);
    chk("f100_prom", prom_out, 12'h100);
    @(posedge clk);
    #1;
    dato_in = 12'h100; listo_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_clear();
    @(negedge clk);
    chk("clrs_prom", prom_out, 0);
    chk("clrs_llena", ventana_llena, 0);
    chk("clrs_ovr", overrun, 0);
    repeat (17) @(posedge clk);
    #1 listo_in = 1'b0;
    repeat (20) @(posedge clk);
    v0 = n_valid;
    for (int i = 0; i < 7; i++) send(12'h100, 20, 20);
    chk("clrs_no_valid", n_valid, v0);
    chk("clrs_ovr2", overrun, 0);
    send(12'h300, 20, 20);
    chk("clrs_avg", prom_out, 12'h140);

    // rst during UPDATE
    @(posedge clk);
    #1;
    dato_in = 12'h555; listo_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 listo_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rstu_prom", prom_out, 0);
    chk("rstu_valid", prom_valid, 0);
    chk("rstu_llena", ventana_llena, 0);
    chk("rstu_ovr", overrun, 0);
    v0 = n_valid;
    @(posedge clk);
    #1;
    dato_in = 12'h010; listo_in = 1'b1;
    model_push(12'h010);
    repeat (100) @(posedge clk);
    #1 listo_in = 1'b0;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 7; i++) send(12'h020, 20, 20);
    chk("held_one_valid", n_valid, v0 + 1);
    chk("held_avg", prom_out, 12'h01E);

    // wrap: values 0..19
    pulse_clr();
    for (int i = 0; i < 20; i++) send(12'(i), 4, 4);
    repeat (10) @(posedge clk);
    chk("wrap_prom", prom_out, 12'h00F);
    chk("drain", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_promedio_movil.md
Name: adc_promedio_movil

Overview:
- Downstream consumer of the ADC receive path. Takes each 12-bit sample latched by the receive top and its completion flag.
- Maintains an N-sample sliding window in a circular buffer with a running sum.
- Outputs the windowed average with a one-cycle valid strobe, for display and control logic running on the system clock.

Parameters:
WIDTH, 12, sample width in bits
LOG2_N, 3, log2 of window length (N = 8)

Ports:
clk  in  1  system clock; single clock domain for all logic
rst  in  1  synchronous, active-high reset
clr  in  1  synchronous window clear, same clock
dato_in  in  WIDTH  latched sample from the receive stage; stable while listo_in high and after
listo_in  in  1  sample-complete level from the capture stage; generated on the divided ADC clock, treated as asynchronous
prom_out  out  WIDTH  registered window average
prom_valid  out  1  one-cycle pulse when prom_out updates
ventana_llena  out  1  high once N samples have been accumulated since reset/clr
overrun  out  1  sticky: a sample edge arrived while busy and was dropped

Behaviour:
- Reset (rst=1 at a clk edge): all of the following are 0: sync flops, state=IDLE, ptr, count, sum, prom_out, prom_valid, ventana_llena, overrun. Buffer contents are not cleared.
- clr: identical effect to rst except the sync flops keep running. clr has priority over a concurrent strobe; that strobe is discarded and does not set overrun. A clr or rst mid-operation abandons the operation with no partial write.
- Input sync: listo_in goes through 2 flops (s1, s2) plus a history flop s3. strobe = s2 & ~s3 (rising edge only). A listo_in held high yields exactly one strobe.
- Buffer: 2^LOG2_N x WIDTH, synchronous read with one cycle of read latency, single write port. ptr has LOG2_N bits and wraps from N-1 to 0. count saturates at N.
- sum: WIDTH+LOG2_N bits (15 by default), unsigned, cannot overflow.
- FSM states: IDLE, READ, UPDATE, OUT.
  - IDLE: on strobe, register dato_in into muestra and go to READ.
  - READ: present address ptr to the buffer; go to UPDATE.
  - UPDATE: viejo = (count==N) ? buf[ptr] : 0. Then sum <= sum + muestra - viejo; buf[ptr] <= muestra; ptr <= ptr+1; count <= min(count+1, N). Go to OUT.
  - OUT: prom_out <= sum[WIDTH+LOG2_N-1:LOG2_N] (truncating divide). prom_valid <= 1 only if count==N. Go to IDLE.
- prom_out updates only when prom_valid fires; during window fill it holds 0.
- ventana_llena = (count==N), registered.
- Latency: let E0 be the first clk edge sampling listo_in=1. Then s2=1 after E1, READ after E2, UPDATE after E3, OUT after E4. prom_valid is high for the single cycle after E5.
- overrun: a strobe in any state other than IDLE is dropped and sets overrun=1. It stays set until rst or clr.
- Every strobe accepted in IDLE is processed exactly once; no sample is counted twice.

Test Plan:
- Reset, then 8 samples of 0x800 with listo_in high 20 cycles and low 20 cycles each -> no prom_valid on samples 1-7; on sample 8, prom_valid pulses once, exactly 5 edges after the first sampled-high edge, with prom_out=0x800 and ventana_llena=1.
- 8 samples of 0xFFF, then 8 of 0x000 -> after the fill, prom_out=0xFFF (sum 0x7FF8). Then successive outputs are 0xDFF, 0xBFF, 0x9FF, 0x7FF, 0x5FF, 0x3FF, 0x1FF, 0x000.
- listo_in pattern high 1, low 1, high 1 -> the first edge is processed; the second falls in READ/UPDATE, is dropped, and overrun=1. overrun stays 1 through a later normal sample and clears on clr.
- Fill the window with 0x100, then pulse clr concurrently with a strobe -> count, sum, prom_out, ventana_llena and overrun all 0. The next 7 samples give no prom_valid; the 8th, 0x300 after seven 0x100, gives prom_out=0x140.
- Assert rst during UPDATE -> all outputs 0 next cycle and no buffer write. listo_in held high for 100 cycles afterwards produces no further strobe until it goes low and high again.
- Window wrap: feed 20 samples with values 0..19 -> the final prom_out is (12+...+19)/8 = 124/8 = 15 (0x00F). Confirms ptr wraps twice and the oldest samples are subtracted correctly.
